// File: rtl/inner_wb_arbiter_pkg.sv
// Shared encodings for the inner Wishbone arbiter: FSM states, the "no owner"
// marker and the default watchdog limit.
package inner_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam logic [1:0] OWNER_NONE      = 2'd3;
  localparam int         TIMEOUT_DEFAULT = 255;

  // Next index in the 0 -> 1 -> 2 -> 0 ring; the "none" code maps to 0.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/inner_wb_arbiter_rr_pick3.sv
// Combinational three-way round-robin pick, zero latency, no backpressure:
// searches from last_i+1 (mod 3) for the first set request bit.
module rr_pick3
  import inner_wb_arbiter_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] grant_o,
  output logic       valid_o
);

  logic [3:0] req_x;
  logic [1:0] p0, p1, p2;

  always_comb begin
    req_x   = {1'b0, req_i};
    p0      = rr_next(last_i);
    p1      = rr_next(p0);
    p2      = rr_next(p1);
    valid_o = |req_i;
    grant_o = p0;
    if (req_x[p0])      grant_o = p0;
    else if (req_x[p1]) grant_o = p1;
    else if (req_x[p2]) grant_o = p2;
  end

endmodule

// File: rtl/inner_wb_arbiter.sv
// Round-robin owner of the inner Wishbone bus for three cache masters; one cycle
// grant latency, ownership held for the whole cycle; watchdog aborts unacked stb.
module inner_wb_arbiter
  import inner_wb_arbiter_pkg::*;
#(
  parameter int WB_ADDR_W = 24,
  parameter int WB_DATA_W = 16,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 m0_wb_cyc,
  input  logic                 m0_wb_stb,
  input  logic                 m0_wb_we,
  input  logic [WB_ADDR_W-1:0] m0_wb_adr,
  input  logic [WB_DATA_W-1:0] m0_wb_o_dat,
  input  logic [1:0]           m0_wb_sel,
  input  logic                 m0_wb_4_burst,
  input  logic                 m0_wb_8_burst,
  output logic [WB_DATA_W-1:0] m0_wb_i_dat,
  output logic                 m0_wb_ack,
  output logic                 m0_wb_err,
  input  logic                 m1_wb_cyc,
  input  logic                 m1_wb_stb,
  input  logic                 m1_wb_we,
  input  logic [WB_ADDR_W-1:0] m1_wb_adr,
  input  logic [WB_DATA_W-1:0] m1_wb_o_dat,
  input  logic [1:0]           m1_wb_sel,
  input  logic                 m1_wb_4_burst,
  input  logic                 m1_wb_8_burst,
  output logic [WB_DATA_W-1:0] m1_wb_i_dat,
  output logic                 m1_wb_ack,
  output logic                 m1_wb_err,
  input  logic                 m2_wb_cyc,
  input  logic                 m2_wb_stb,
  input  logic                 m2_wb_we,
  input  logic [WB_ADDR_W-1:0] m2_wb_adr,
  input  logic [WB_DATA_W-1:0] m2_wb_o_dat,
  input  logic [1:0]           m2_wb_sel,
  input  logic                 m2_wb_4_burst,
  input  logic                 m2_wb_8_burst,
  output logic [WB_DATA_W-1:0] m2_wb_i_dat,
  output logic                 m2_wb_ack,
  output logic                 m2_wb_err,
  output logic                 inner_wb_cyc,
  output logic                 inner_wb_stb,
  output logic                 inner_wb_we,
  output logic [WB_ADDR_W-1:0] inner_wb_adr,
  output logic [WB_DATA_W-1:0] inner_wb_o_dat,
  output logic [1:0]           inner_wb_sel,
  output logic                 inner_wb_4_burst,
  output logic                 inner_wb_8_burst,
  input  logic [WB_DATA_W-1:0] inner_wb_i_dat,
  input  logic                 inner_wb_ack,
  input  logic                 inner_wb_err,
  output logic [1:0]           o_owner,
  output logic                 o_timeout
);

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wd_hit;

  logic [2:0] req;
  logic [1:0] pick_gnt;
  logic       pick_vld;

  logic                 own_cyc, own_stb, own_we, own_b4, own_b8;
  logic [WB_ADDR_W-1:0] own_adr;
  logic [WB_DATA_W-1:0] own_dat;
  logic [1:0]           own_sel;

  assign req = {m2_wb_cyc & m2_wb_stb, m1_wb_cyc & m1_wb_stb, m0_wb_cyc & m0_wb_stb};

  rr_pick3 u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (pick_gnt),
    .valid_o (pick_vld)
  );

  always_comb begin
    own_cyc = 1'b0; own_stb = 1'b0; own_we = 1'b0; own_b4 = 1'b0; own_b8 = 1'b0;
    own_adr = '0;   own_dat = '0;   own_sel = '0;
    case (owner_q)
      2'd0: begin
        own_cyc = m0_wb_cyc; own_stb = m0_wb_stb; own_we = m0_wb_we; own_adr = m0_wb_adr;
        own_dat = m0_wb_o_dat; own_sel = m0_wb_sel; own_b4 = m0_wb_4_burst; own_b8 = m0_wb_8_burst;
      end
      2'd1: begin
        own_cyc = m1_wb_cyc; own_stb = m1_wb_stb; own_we = m1_wb_we; own_adr = m1_wb_adr;
        own_dat = m1_wb_o_dat; own_sel = m1_wb_sel; own_b4 = m1_wb_4_burst; own_b8 = m1_wb_8_burst;
      end
      2'd2: begin
        own_cyc = m2_wb_cyc; own_stb = m2_wb_stb; own_we = m2_wb_we; own_adr = m2_wb_adr;
        own_dat = m2_wb_o_dat; own_sel = m2_wb_sel; own_b4 = m2_wb_4_burst; own_b8 = m2_wb_8_burst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_NONE;
      last_q  <= 2'd2;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wd_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_OWN;
          owner_d = pick_gnt;
          last_d  = pick_gnt;
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        if (!own_cyc) begin
          state_d = ST_GAP;
          owner_d = OWNER_NONE;
          cnt_d   = '0;
        end else if (inner_wb_ack || inner_wb_err) begin
          // A termination on the limit cycle still completes the beat.
          cnt_d = '0;
        end else if (own_stb) begin
          if (({1'b0, cnt_q} + 9'd1) >= TO_LIM) begin
            wd_hit  = 1'b1;
            state_d = ST_ABORT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_ABORT: begin
        if (!own_cyc) begin
          state_d = ST_GAP;
          owner_d = OWNER_NONE;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    inner_wb_cyc = 1'b0; inner_wb_stb = 1'b0; inner_wb_we = 1'b0;
    inner_wb_adr = '0;   inner_wb_o_dat = '0; inner_wb_sel = '0;
    inner_wb_4_burst = 1'b0; inner_wb_8_burst = 1'b0;
    m0_wb_i_dat = '0; m0_wb_ack = 1'b0; m0_wb_err = 1'b0;
    m1_wb_i_dat = '0; m1_wb_ack = 1'b0; m1_wb_err = 1'b0;
    m2_wb_i_dat = '0; m2_wb_ack = 1'b0; m2_wb_err = 1'b0;
    o_timeout = wd_hit;
    if (state_q == ST_OWN) begin
      inner_wb_cyc = own_cyc; inner_wb_stb = own_stb; inner_wb_we = own_we;
      inner_wb_adr = own_adr; inner_wb_o_dat = own_dat; inner_wb_sel = own_sel;
      inner_wb_4_burst = own_b4; inner_wb_8_burst = own_b8;
      case (owner_q)
        2'd0: begin m0_wb_i_dat = inner_wb_i_dat; m0_wb_ack = inner_wb_ack; m0_wb_err = inner_wb_err; end
        2'd1: begin m1_wb_i_dat = inner_wb_i_dat; m1_wb_ack = inner_wb_ack; m1_wb_err = inner_wb_err; end
        2'd2: begin m2_wb_i_dat = inner_wb_i_dat; m2_wb_ack = inner_wb_ack; m2_wb_err = inner_wb_err; end
        default: ;
      endcase
    end else if (state_q == ST_ABORT) begin
      // Bus is released; the stranded owner is told via a sticky err.
      case (owner_q)
        2'd0: m0_wb_err = 1'b1;
        2'd1: m1_wb_err = 1'b1;
        2'd2: m2_wb_err = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_owner = owner_q;

endmodule

// File: tb/tb_inner_wb_arbiter.sv
// Scoreboarded bench for inner_wb_arbiter: expected grant order is queued when
// requests are driven and popped when the arbiter hands out the bus.
module tb_inner_wb_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    cyc, stb, we, b4, b8;
  logic [AW-1:0] adr  [3];
  logic [DW-1:0] wdat [3];
  logic [1:0]    bsel [3];
  logic [DW-1:0] idat [3];
  logic [2:0]    ack, err;

  logic          icyc, istb, iwe, ib4, ib8;
  logic [AW-1:0] iadr;
  logic [DW-1:0] iodat;
  logic [1:0]    isel;
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err;
  logic [1:0]    owner;
  logic          tmo;

  int checks = 0;
  int errors = 0;
  int gq[$];

  inner_wb_arbiter #(.WB_ADDR_W(AW), .WB_DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .m0_wb_cyc(cyc[0]), .m0_wb_stb(stb[0]), .m0_wb_we(we[0]), .m0_wb_adr(adr[0]),
    .m0_wb_o_dat(wdat[0]), .m0_wb_sel(bsel[0]), .m0_wb_4_burst(b4[0]), .m0_wb_8_burst(b8[0]),
    .m0_wb_i_dat(idat[0]), .m0_wb_ack(ack[0]), .m0_wb_err(err[0]),
    .m1_wb_cyc(cyc[1]), .m1_wb_stb(stb[1]), .m1_wb_we(we[1]), .m1_wb_adr(adr[1]),
    .m1_wb_o_dat(wdat[1]), .m1_wb_sel(bsel[1]), .m1_wb_4_burst(b4[1]), .m1_wb_8_burst(b8[1]),
    .m1_wb_i_dat(idat[1]), .m1_wb_ack(ack[1]), .m1_wb_err(err[1]),
    .m2_wb_cyc(cyc[2]), .m2_wb_stb(stb[2]), .m2_wb_we(we[2]), .m2_wb_adr(adr[2]),
    .m2_wb_o_dat(wdat[2]), .m2_wb_sel(bsel[2]), .m2_wb_4_burst(b4[2]), .m2_wb_8_burst(b8[2]),
    .m2_wb_i_dat(idat[2]), .m2_wb_ack(ack[2]), .m2_wb_err(err[2]),
    .inner_wb_cyc(icyc), .inner_wb_stb(istb), .inner_wb_we(iwe), .inner_wb_adr(iadr),
    .inner_wb_o_dat(iodat), .inner_wb_sel(isel), .inner_wb_4_burst(ib4), .inner_wb_8_burst(ib8),
    .inner_wb_i_dat(s_dat), .inner_wb_ack(s_ack), .inner_wb_err(s_err),
    .o_owner(owner), .o_timeout(tmo)
  );

  task automatic do_reset();
    rst = 1'b1;
    cyc = '0; stb = '0; we = '0; b4 = '0; b8 = '0;
    s_ack = 1'b0; s_err = 1'b0; s_dat = '0;
    for (int i = 0; i < 3; i++) begin
      adr[i]  = {4'(i + 1), 20'h01234};
      wdat[i] = {4'(i + 1), 12'hABC};
      bsel[i] = 2'b11;
    end
    gq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    int exp;
    #2 rst = 1'b1;
    cyc = '1; stb = '1; s_ack = 1'b1;
    #1;
    checks++; if (icyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", icyc); end
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL reset_owner: got %0d want 3", owner); end
    checks++; if (ack !== 3'b000 || err !== 3'b000 || tmo !== 1'b0)
      begin errors++; $display("FAIL reset_term: ack %b err %b tmo %b want 0", ack, err, tmo); end
    do_reset();
    @(posedge clk); #1;
    cyc = '1; stb = '1;
    gq.push_back(0);
    #1;
    checks++; if (icyc !== 1'b0) begin errors++; $display("FAIL reset_latency: cyc %b want 0 before grant", icyc); end
    @(posedge clk); #2;
    exp = gq.pop_front();
    checks++; if (int'(owner) !== exp) begin errors++; $display("FAIL reset_first_grant: got %0d want %0d", owner, exp); end
    checks++; if (iadr !== adr[exp] || icyc !== 1'b1)
      begin errors++; $display("FAIL reset_first_adr: adr %h cyc %b want %h 1", iadr, icyc, adr[exp]); end
  endtask

  task automatic test_rotation();
    int exp, cur, idle, prev, got;
    logic [2:0] drop;
    do_reset();
    gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(0);
    got = 0; idle = 0; prev = 3; cur = 0; drop = '0;
    for (int t = 0; t < 80 && got < 4; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin cyc[i] = ~drop[i]; stb[i] = ~drop[i]; end
      s_ack = 1'b0; s_dat = 16'hD000 + 16'(t);
      #1;
      if (owner !== 2'd3 && int'(owner) != prev) begin
        exp = gq.pop_front(); cur = exp;
        checks++; if (int'(owner) !== exp) begin errors++; $display("FAIL rr_order: grant %0d got %0d want %0d", got, owner, exp); end
        checks++; if (iadr !== adr[exp]) begin errors++; $display("FAIL rr_adr: got %h want %h", iadr, adr[exp]); end
        if (got > 0) begin
          checks++; if (idle !== 2) begin errors++; $display("FAIL rr_gap: idle %0d want 2", idle); end
        end
        got++; idle = 0;
      end
      if (owner === 2'd3) idle++;
      s_ack = icyc & istb;
      #1;
      if (s_ack) begin
        checks++;
        if (ack !== 3'(1 << cur) || idat[cur] !== s_dat)
          begin errors++; $display("FAIL rr_route: ack %b dat %h want %b %h", ack, idat[cur], 3'(1 << cur), s_dat); end
      end
      drop = ack;
      prev = int'(owner);
    end
    checks++; if (got !== 4) begin errors++; $display("FAIL rr_count: grants %0d want 4", got); end
    cyc = '0; stb = '0; s_ack = 1'b0;
  endtask

  task automatic test_burst();
    int exp, cur, prev, a1, a2, b8_beats, drop_t, g_t;
    do_reset();
    gq.push_back(1); gq.push_back(2);
    cyc[1] = 1'b1; stb[1] = 1'b1; b8[1] = 1'b1;
    cyc[2] = 1'b1; stb[2] = 1'b1;
    a1 = 0; a2 = 0; b8_beats = 0; drop_t = -1; g_t = -1; prev = 3; cur = 3;
    for (int t = 0; t < 60 && g_t < 0; t++) begin
      @(posedge clk); #1;
      if (a1 == 8 && drop_t < 0) begin cyc[1] = 1'b0; stb[1] = 1'b0; b8[1] = 1'b0; drop_t = t; end
      s_ack = 1'b0; s_dat = 16'h8000 + 16'(t);
      #1;
      if (owner !== 2'd3 && int'(owner) != prev) begin
        exp = gq.pop_front(); cur = exp;
        checks++; if (int'(owner) !== exp) begin errors++; $display("FAIL burst_order: got %0d want %0d", owner, exp); end
        if (exp == 2) g_t = t;
      end
      prev = int'(owner);
      s_ack = icyc & istb & (cur == 1);
      #1;
      if (ack[1]) a1++;
      if (ack[2]) a2++;
      if (s_ack && ib8) b8_beats++;
    end
    checks++; if (a1 !== 8) begin errors++; $display("FAIL burst_m1_acks: got %0d want 8", a1); end
    checks++; if (a2 !== 0) begin errors++; $display("FAIL burst_m2_acks: got %0d want 0", a2); end
    checks++; if (b8_beats !== 8) begin errors++; $display("FAIL burst_b8_beats: got %0d want 8", b8_beats); end
    checks++; if (g_t < 0 || drop_t < 0 || g_t - drop_t !== 3)
      begin errors++; $display("FAIL burst_turnaround: got %0d want 3", g_t - drop_t); end
    cyc = '0; stb = '0; s_ack = 1'b0;
  endtask

  task automatic test_watchdog();
    int exp, n, tpulse, bad;
    do_reset();
    gq.push_back(2);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
    n = 0; tpulse = -1;
    for (int t = 0; t < 60 && tpulse < 0; t++) begin
      @(posedge clk); #2;
      if (owner !== 2'd3 && gq.size() > 0) begin
        exp = gq.pop_front();
        checks++; if (int'(owner) !== exp) begin errors++; $display("FAIL wd_grant: got %0d want %0d", owner, exp); end
      end
      if (icyc && istb) n++;
      if (tmo) tpulse = n;
    end
    checks++; if (tpulse !== TO) begin errors++; $display("FAIL wd_pulse: at stb cycle %0d want %0d", tpulse, TO); end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      if (icyc !== 1'b0 || istb !== 1'b0 || err !== 3'b100 || tmo !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wd_abort_hold: %0d bad cycles want 0", bad); end
    @(posedge clk); #1;
    cyc[2] = 1'b0; stb[2] = 1'b0;
    @(posedge clk); #2;
    checks++; if (err !== 3'b000 || icyc !== 1'b0) begin errors++; $display("FAIL wd_release: err %b cyc %b want 000 0", err, icyc); end
    @(posedge clk); #2;
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL wd_idle_owner: got %0d want 3", owner); end
  endtask

  task automatic test_ack_vs_timeout();
    int exp, granted, tcount, acks, errs;
    do_reset();
    gq.push_back(0);
    cyc[0] = 1'b1; stb[0] = 1'b1;
    granted = 0;
    for (int t = 0; t < 10 && granted == 0; t++) begin
      @(posedge clk); #2;
      if (owner !== 2'd3) begin
        exp = gq.pop_front(); granted = 1;
        checks++; if (int'(owner) !== exp) begin errors++; $display("FAIL avt_grant: got %0d want %0d", owner, exp); end
      end
    end
    if (granted == 0) begin errors++; checks++; $display("FAIL avt_grant: no grant want 0"); end
    tcount = 0; acks = 0; errs = 0;
    // Stall cycle 1 was the grant cycle; acks land on stall cycles 16 and 32.
    for (int c = 2; c <= 32; c++) begin
      @(posedge clk); #1;
      s_ack = (c % TO == 0);
      #1;
      if (tmo) tcount++;
      if (ack[0]) acks++;
      if (err !== 3'b000) errs++;
      if (c == TO) begin
        checks++; if (ack[0] !== 1'b1 || icyc !== 1'b1) begin errors++; $display("FAIL avt_edge_ack: ack %b cyc %b want 1 1", ack[0], icyc); end
      end
    end
    checks++; if (tcount !== 0) begin errors++; $display("FAIL avt_no_timeout: pulses %0d want 0", tcount); end
    checks++; if (acks !== 2 || errs !== 0) begin errors++; $display("FAIL avt_acks: acks %0d errs %0d want 2 0", acks, errs); end
    @(posedge clk); #1;
    s_ack = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
    @(posedge clk); #2;
    checks++; if (owner !== 2'd3 || icyc !== 1'b0) begin errors++; $display("FAIL avt_complete: owner %0d cyc %b want 3 0", owner, icyc); end
  endtask

  task automatic test_reset_mid_burst();
    int exp, beats, hit;
    do_reset();
    gq.push_back(0);
    cyc[0] = 1'b1; stb[0] = 1'b1; b4[0] = 1'b1;
    beats = 0; hit = 0;
    for (int t = 0; t < 20 && hit == 0; t++) begin
      @(posedge clk); #1;
      s_ack = 1'b0; s_dat = 16'h4000 + 16'(t);
      #1;
      if (owner !== 2'd3 && gq.size() > 0) begin
        exp = gq.pop_front();
        checks++; if (int'(owner) !== exp) begin errors++; $display("FAIL mid_grant: got %0d want %0d", owner, exp); end
      end
      s_ack = icyc & istb;
      #1;
      if (ack[0]) beats++;
      if (beats == 3) begin
        checks++; if (ib4 !== 1'b1) begin errors++; $display("FAIL mid_b4: got %b want 1", ib4); end
        rst = 1'b1;
        #1;
        checks++; if (icyc !== 1'b0 || istb !== 1'b0 || iadr !== '0 || ib4 !== 1'b0)
          begin errors++; $display("FAIL mid_bus_zero: cyc %b stb %b adr %h b4 %b want 0", icyc, istb, iadr, ib4); end
        checks++; if (ack !== 3'b000 || idat[0] !== '0 || owner !== 2'd3)
          begin errors++; $display("FAIL mid_term_zero: ack %b dat %h owner %0d want 000 0 3", ack, idat[0], owner); end
        hit = 1;
      end
    end
    if (hit == 0) begin errors++; checks++; $display("FAIL mid_beats: got %0d want 3", beats); end
    s_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = '1; stb = '1; b4 = '0;
    gq.push_back(0);
    #1;
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL mid_release_owner: got %0d want 3", owner); end
    @(posedge clk); #2;
    exp = gq.pop_front();
    checks++; if (int'(owner) !== exp || iadr !== adr[exp])
      begin errors++; $display("FAIL mid_priority: owner %0d adr %h want %0d %h", owner, iadr, exp, adr[exp]); end
    cyc = '0; stb = '0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_burst();
    test_watchdog();
    test_ack_vs_timeout();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
